aria_seq_ctrl: RTL and testbench

Top-level sequencer for the ARIA 1.1 core. It runs key setup by computing W0..W3 and writing the round-key file. It then steps the round datapath through encryption or decryption of one 128-bit block, driving round-key addresses and round-type selects. It sits upstream of the round-key store and round datapath, and provides the write-enable, address and round-count control those stages consume.

---
 rtl/aria_seq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_aria_seq_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aria_seq_ctrl.sv
// -----------------------------------------------------------------------------
// aria_seq_ctrl
//
// Top-level sequencer for the ARIA 1.1 core. After a key_valid pulse it walks
// through W0..W3 generation and writes every round key into the round-key file.
// After that it runs one 128-bit block per accepted blk_valid through the round
// datapath, in either the encrypt or the decrypt direction.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   aria_mode    : key length (00=128, 01=192, 10/11=256), sampled on key accept
//   key_valid    : start key setup
//   blk_valid    : start one block operation (only while keys are ready)
//   decrypt      : block direction, sampled on block accept
//   key_ready    : round keys valid
//   blk_ready    : blk_valid is accepted this cycle
//   busy         : key setup or block operation in progress
//   w_en, w_sel  : W-register load strobe and word index
//   rk_wr_en     : round-key file write strobe
//   rk_rd_en     : round-key file read strobe
//   rk_addr      : round-key file address (holds when no strobe is active)
//   round_en     : round datapath enable
//   round_odd    : 1 = FO round, 0 = FE round
//   round_last   : final FE round (key addition, no diffusion)
//   final_add    : closing round-key addition
//   out_valid    : one-cycle pulse, datapath output holds the result
// -----------------------------------------------------------------------------
module aria_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] aria_mode,
    input  logic       key_valid,
    input  logic       blk_valid,
    input  logic       decrypt,
    output logic       key_ready,
    output logic       blk_ready,
    output logic       busy,
    output logic       w_en,
    output logic [1:0] w_sel,
    output logic       rk_wr_en,
    output logic       rk_rd_en,
    output logic [4:0] rk_addr,
    output logic       round_en,
    output logic       round_odd,
    output logic       round_last,
    output logic       final_add,
    output logic       out_valid
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_GEN   = 3'd1,
        S_RK_GEN  = 3'd2,
        S_KEY_RDY = 3'd3,
        S_ROUND   = 3'd4,
        S_FINAL   = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    // Number of round keys for a mode; 2'b11 is handled as ARIA-256.
    function automatic logic [4:0] n_rk_of(input logic [1:0] mode);
        case (mode)
            2'b00:   n_rk_of = 5'd13;
            2'b01:   n_rk_of = 5'd15;
            default: n_rk_of = 5'd17;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [3:0] r_q, r_d;        // round counter, 0..N_r-1
    logic [4:0] idx_q, idx_d;    // W word index / round-key write index
    logic [1:0] mode_q, mode_d;
    logic       dec_q, dec_d;

    // Registered outputs
    logic       key_ready_q, key_ready_d;
    logic       blk_ready_q, blk_ready_d;
    logic       busy_q, busy_d;
    logic       w_en_q, w_en_d;
    logic [1:0] w_sel_q, w_sel_d;
    logic       rk_wr_en_q, rk_wr_en_d;
    logic       rk_rd_en_q, rk_rd_en_d;
    logic [4:0] rk_addr_q, rk_addr_d;
    logic       round_en_q, round_en_d;
    logic       round_odd_q, round_odd_d;
    logic       round_last_q, round_last_d;
    logic       final_add_q, final_add_d;
    logic       out_valid_q, out_valid_d;

    logic [4:0] n_rk_cur;   // round keys for the mode in force now
    logic [4:0] n_rk_nxt;   // round keys for the mode in force next cycle

    assign n_rk_cur = n_rk_of(mode_q);
    assign n_rk_nxt = n_rk_of(mode_d);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        dec_d   = dec_q;

        unique case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    state_d = S_W_GEN;
                    idx_d   = 5'd0;
                    mode_d  = aria_mode;
                end
            end

            S_W_GEN: begin
                if (idx_q == 5'd3) begin
                    state_d = S_RK_GEN;
                    idx_d   = 5'd0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end

            S_RK_GEN: begin
                if (idx_q == n_rk_cur - 5'd1) begin
                    state_d = S_KEY_RDY;
                    idx_d   = 5'd0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end

            S_KEY_RDY: begin
                // A new key always wins over a block request in the same cycle.
                if (key_valid) begin
                    state_d = S_W_GEN;
                    idx_d   = 5'd0;
                    mode_d  = aria_mode;
                end else if (blk_valid) begin
                    state_d = S_ROUND;
                    dec_d   = decrypt;
                    r_d     = 4'd0;
                end
            end

            S_ROUND: begin
                // Last round is r = N_r-1 = N_rk-2; compared at 5 bits so that
                // the ARIA-256 limit of 15 never needs a wrapping counter.
                if ({1'b0, r_q} == n_rk_cur - 5'd2) begin
                    state_d = S_FINAL;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end

            S_FINAL: state_d = S_DONE;

            S_DONE:  state_d = S_KEY_RDY;

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so every output is a flop
    // that reflects the state the machine is about to be in.
    // ------------------------------------------------------------------
    always_comb begin
        key_ready_d  = 1'b0;
        blk_ready_d  = 1'b0;
        busy_d       = 1'b0;
        w_en_d       = 1'b0;
        w_sel_d      = 2'd0;
        rk_wr_en_d   = 1'b0;
        rk_rd_en_d   = 1'b0;
        rk_addr_d    = rk_addr_q;
        round_en_d   = 1'b0;
        round_odd_d  = 1'b0;
        round_last_d = 1'b0;
        final_add_d  = 1'b0;
        out_valid_d  = 1'b0;

        unique case (state_d)
            S_IDLE: ;

            S_W_GEN: begin
                busy_d  = 1'b1;
                w_en_d  = 1'b1;
                w_sel_d = idx_d[1:0];
            end

            S_RK_GEN: begin
                busy_d     = 1'b1;
                rk_wr_en_d = 1'b1;
                rk_addr_d  = idx_d;
            end

            S_KEY_RDY: begin
                key_ready_d = 1'b1;
                blk_ready_d = 1'b1;
            end

            S_ROUND: begin
                key_ready_d  = 1'b1;
                busy_d       = 1'b1;
                round_en_d   = 1'b1;
                rk_rd_en_d   = 1'b1;
                // Decryption consumes the round keys in reverse order.
                rk_addr_d    = dec_d ? (n_rk_nxt - 5'd1 - {1'b0, r_d}) : {1'b0, r_d};
                round_odd_d  = ~r_d[0];
                round_last_d = ({1'b0, r_d} == n_rk_nxt - 5'd2);
            end

            S_FINAL: begin
                key_ready_d = 1'b1;
                busy_d      = 1'b1;
                final_add_d = 1'b1;
                rk_rd_en_d  = 1'b1;
                rk_addr_d   = dec_d ? 5'd0 : (n_rk_nxt - 5'd1);
            end

            S_DONE: begin
                key_ready_d = 1'b1;
                busy_d      = 1'b1;
                out_valid_d = 1'b1;
            end

            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            r_q          <= 4'd0;
            idx_q        <= 5'd0;
            mode_q       <= 2'b00;
            dec_q        <= 1'b0;
            key_ready_q  <= 1'b0;
            blk_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            w_en_q       <= 1'b0;
            w_sel_q      <= 2'd0;
            rk_wr_en_q   <= 1'b0;
            rk_rd_en_q   <= 1'b0;
            rk_addr_q    <= 5'd0;
            round_en_q   <= 1'b0;
            round_odd_q  <= 1'b0;
            round_last_q <= 1'b0;
            final_add_q  <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            idx_q        <= idx_d;
            mode_q       <= mode_d;
            dec_q        <= dec_d;
            key_ready_q  <= key_ready_d;
            blk_ready_q  <= blk_ready_d;
            busy_q       <= busy_d;
            w_en_q       <= w_en_d;
            w_sel_q      <= w_sel_d;
            rk_wr_en_q   <= rk_wr_en_d;
            rk_rd_en_q   <= rk_rd_en_d;
            rk_addr_q    <= rk_addr_d;
            round_en_q   <= round_en_d;
            round_odd_q  <= round_odd_d;
            round_last_q <= round_last_d;
            final_add_q  <= final_add_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign key_ready  = key_ready_q;
    // blk_ready promises acceptance in this very cycle, so a concurrent
    // key_valid (which takes priority) has to mask the registered flag.
    assign blk_ready  = blk_ready_q & ~key_valid;
    assign busy       = busy_q;
    assign w_en       = w_en_q;
    assign w_sel      = w_sel_q;
    assign rk_wr_en   = rk_wr_en_q;
    assign rk_rd_en   = rk_rd_en_q;
    assign rk_addr    = rk_addr_q;
    assign round_en   = round_en_q;
    assign round_odd  = round_odd_q;
    assign round_last = round_last_q;
    assign final_add  = final_add_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_aria_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aria_seq_ctrl
//
// Directed sequence with randomized side traffic. Expected per-cycle output
// vectors are built from the key-setup and block timelines (W words, round-key
// write order, round-key read order per direction) and compared against the
// sequencer outputs one cycle at a time.
// -----------------------------------------------------------------------------
module tb_aria_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] aria_mode = 2'b00;
    logic       key_valid = 1'b0;
    logic       blk_valid = 1'b0;
    logic       decrypt = 1'b0;

    logic       key_ready, blk_ready, busy, w_en, rk_wr_en, rk_rd_en;
    logic       round_en, round_odd, round_last, final_add, out_valid;
    logic [1:0] w_sel;
    logic [4:0] rk_addr;

    aria_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .aria_mode  (aria_mode),
        .key_valid  (key_valid),
        .blk_valid  (blk_valid),
        .decrypt    (decrypt),
        .key_ready  (key_ready),
        .blk_ready  (blk_ready),
        .busy       (busy),
        .w_en       (w_en),
        .w_sel      (w_sel),
        .rk_wr_en   (rk_wr_en),
        .rk_rd_en   (rk_rd_en),
        .rk_addr    (rk_addr),
        .round_en   (round_en),
        .round_odd  (round_odd),
        .round_last (round_last),
        .final_add  (final_add),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       key_ready;
        logic       blk_ready;
        logic       busy;
        logic       w_en;
        logic [1:0] w_sel;
        logic       rk_wr_en;
        logic       rk_rd_en;
        logic [4:0] rk_addr;
        logic       round_en;
        logic       round_odd;
        logic       round_last;
        logic       final_add;
        logic       out_valid;
    } vec_t;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    // Reference-model state: what the sequencer should be holding.
    logic [4:0] m_addr = 5'd0;   // last round-key address driven
    bit         m_keys = 1'b0;   // round keys valid
    logic [1:0] m_mode = 2'b00;  // key length of the installed key

    // out_valid spacing monitor
    int ov_last = -1;
    int ov_gap  = 0;
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (ov_last >= 0) ov_gap = cyc - ov_last;
            ov_last = cyc;
        end
    end

    function automatic int nrk(input logic [1:0] m);
        case (m)
            2'b00:   return 13;
            2'b01:   return 15;
            default: return 17;
        endcase
    endfunction

    function automatic vec_t observed();
        vec_t v;
        v.key_ready  = key_ready;
        v.blk_ready  = blk_ready;
        v.busy       = busy;
        v.w_en       = w_en;
        v.w_sel      = w_sel;
        v.rk_wr_en   = rk_wr_en;
        v.rk_rd_en   = rk_rd_en;
        v.rk_addr    = rk_addr;
        v.round_en   = round_en;
        v.round_odd  = round_odd;
        v.round_last = round_last;
        v.final_add  = final_add;
        v.out_valid  = out_valid;
        return v;
    endfunction

    function automatic vec_t base();
        vec_t v;
        v = '0;
        v.key_ready = m_keys;
        v.rk_addr   = m_addr;
        return v;
    endfunction

    task automatic check(input string tag, input vec_t exp_v);
        vec_t got;
        got = observed();
        n_asserts++;
        assert (got === exp_v) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed=%h expected=%h", tag, cyc, got, exp_v);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp_i);
        n_asserts++;
        assert (got === exp_i) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp_i);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Random activity on inputs that must be ignored while busy.
    task automatic noise();
        key_valid = 1'($urandom_range(0, 1));
        blk_valid = 1'($urandom_range(0, 1));
        aria_mode = 2'($urandom_range(0, 3));
        decrypt   = 1'($urandom_range(0, 1));
    endtask

    // Key setup from IDLE or KEY_RDY, ending with a KEY_RDY check.
    task automatic key_setup(input logic [1:0] m, input bit with_blk, input string tag);
        vec_t e;
        int   n;
        key_valid = 1'b1;
        blk_valid = with_blk;
        aria_mode = m;
        decrypt   = 1'($urandom_range(0, 1));
        if (m_keys) begin
            #1;
            e = base();
            e.blk_ready = 1'b0;   // key_valid pending, block not accepted
            check({tag, "_accept"}, e);
        end
        step();
        m_keys = 1'b0;
        m_mode = m;
        n = nrk(m);
        for (int i = 0; i < 4; i++) begin
            e = base();
            e.busy  = 1'b1;
            e.w_en  = 1'b1;
            e.w_sel = 2'(i);
            check({tag, "_wgen"}, e);
            noise();
            step();
        end
        for (int a = 0; a < n; a++) begin
            m_addr = 5'(a);
            e = base();
            e.busy     = 1'b1;
            e.rk_wr_en = 1'b1;
            check({tag, "_rkgen"}, e);
            noise();
            step();
        end
        key_valid = 1'b0;
        blk_valid = 1'b0;
        #1;
        m_keys = 1'b1;
        e = base();
        e.blk_ready = 1'b1;
        check({tag, "_keyrdy"}, e);
    endtask

    // One block from KEY_RDY; hold keeps blk_valid high for a back-to-back start.
    task automatic block(input bit dec, input bit hold, input string tag);
        vec_t e;
        int   n;
        n = nrk(m_mode);
        key_valid = 1'b0;
        blk_valid = 1'b1;
        decrypt   = dec;
        step();
        for (int r = 0; r < n - 1; r++) begin
            m_addr = dec ? 5'(n - 1 - r) : 5'(r);
            e = base();
            e.busy       = 1'b1;
            e.round_en   = 1'b1;
            e.rk_rd_en   = 1'b1;
            e.round_odd  = (r % 2 == 0);
            e.round_last = (r == n - 2);
            check({tag, "_round"}, e);
            noise();
            step();
        end
        m_addr = dec ? 5'd0 : 5'(n - 1);
        e = base();
        e.busy      = 1'b1;
        e.final_add = 1'b1;
        e.rk_rd_en  = 1'b1;
        check({tag, "_final"}, e);
        noise();
        step();
        e = base();
        e.busy      = 1'b1;
        e.out_valid = 1'b1;
        check({tag, "_done"}, e);
        key_valid = 1'b0;
        blk_valid = hold;
        decrypt   = dec;
        step();
        e = base();
        e.blk_ready = 1'b1;
        check({tag, "_keyrdy"}, e);
    endtask

    initial begin
        vec_t e;

        // Reset state, and blk_valid ignored in IDLE
        rst_n = 1'b0;
        #20;
        check("reset", '0);
        rst_n = 1'b1;
        blk_valid = 1'b1;
        decrypt   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_blk_ignored", '0);
        end
        blk_valid = 1'b0;

        // ARIA-128 key setup, encrypt and decrypt
        key_setup(2'b00, 1'b0, "k128");
        block(1'b0, 1'b0, "enc128");
        block(1'b1, 1'b0, "dec128");

        // ARIA-256 decrypt, then mode 11 which must behave identically
        key_setup(2'b10, 1'b0, "k256");
        block(1'b1, 1'b0, "dec256");
        key_setup(2'b11, 1'b0, "k256b");
        block(1'b1, 1'b0, "dec256b");

        // ARIA-192 continuous blk_valid: a new block every 17 cycles
        key_setup(2'b01, 1'b0, "k192");
        ov_last = -1;
        ov_gap  = 0;
        block(1'b0, 1'b1, "b2b192a");
        block(1'b1, 1'b1, "b2b192b");
        block(1'b0, 1'b0, "b2b192c");
        check_int("ov_period192", ov_gap, nrk(2'b01) + 2);

        // key_valid and blk_valid together in KEY_RDY: key setup wins
        key_setup(2'b00, 1'b0, "k128r");
        key_setup(2'b01, 1'b1, "collide");

        // Reset in the middle of a block
        blk_valid = 1'b1;
        decrypt   = 1'b1;
        step();
        blk_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        m_addr = 5'd0;
        m_keys = 1'b0;
        check("reset_mid_round", '0);
        step();
        rst_n = 1'b1;
        blk_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_reset_blk_ignored", '0);
        end
        blk_valid = 1'b0;

        // Randomized key lengths and directions
        for (int k = 0; k < 5; k++) begin
            key_setup(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand_key");
            block(1'($urandom_range(0, 1)), 1'b0, "rand_blk_a");
            block(1'($urandom_range(0, 1)), 1'b0, "rand_blk_b");
        end

        e = base();
        e.blk_ready = 1'b1;
        step();
        check("final_keyrdy", e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
